// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register file: opcode encoding and the stored instruction word.
// instruction_t is laid out for DEFAULT_OP_W; the register file packs its words in the same field order.
package instr_register_pkg;

  localparam int DEFAULT_OP_W = 32;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef struct packed {
    opcode_t                          opc;
    logic signed [DEFAULT_OP_W-1:0]   op_a;
    logic signed [DEFAULT_OP_W-1:0]   op_b;
    logic signed [2*DEFAULT_OP_W-1:0] result;
    logic                             err;
  } instruction_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational ALU producing a full-width (2*OP_W) signed result; zero latency, no flow control.
// Divide/modulo exist only when INSTR_REGISTER_DIV_EN is defined; otherwise they report err.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_W = DEFAULT_OP_W
) (
  input  opcode_t                  opcode_i,
  input  logic signed [OP_W-1:0]   op_a_i,
  input  logic signed [OP_W-1:0]   op_b_i,
  output logic signed [2*OP_W-1:0] result_o,
  output logic                     err_o
);

  logic signed [2*OP_W-1:0] a_ext;
  logic signed [2*OP_W-1:0] b_ext;

  // Working at 2*OP_W keeps MULT and the -MIN/-1 divide free of truncation.
  assign a_ext = {{OP_W{op_a_i[OP_W-1]}}, op_a_i};
  assign b_ext = {{OP_W{op_b_i[OP_W-1]}}, op_b_i};

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (opcode_i)
      ZERO:  result_o = '0;
      PASSA: result_o = a_ext;
      PASSB: result_o = b_ext;
      ADD:   result_o = a_ext + b_ext;
      SUB:   result_o = a_ext - b_ext;
      MULT:  result_o = a_ext * b_ext;
`ifdef INSTR_REGISTER_DIV_EN
      DIV: begin
        if (op_b_i == '0) err_o = 1'b1;
        else              result_o = a_ext / b_ext;
      end
      MOD: begin
        if (op_b_i == '0) err_o = 1'b1;
        else              result_o = a_ext % b_ext;
      end
`else
      DIV:   err_o = 1'b1;
      MOD:   err_o = 1'b1;
`endif
      default: begin
        result_o = '0;
        err_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_register_alu.sv
// Register file of computed instructions; 1-cycle registered read, read-before-write, writes never stall.
// Divider is built only with INSTR_REGISTER_DIV_EN; word packing matches instruction_t field order.
module instr_register_alu
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int OP_W  = DEFAULT_OP_W,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_en,
  input  logic                   clear,
  input  logic [PTR_W-1:0]       write_pointer,
  input  opcode_t                opcode,
  input  logic signed [OP_W-1:0] operand_a,
  input  logic signed [OP_W-1:0] operand_b,
  input  logic [PTR_W-1:0]       read_pointer,
  output logic [4*OP_W+3:0]      instruction_word,
  output logic                   read_err,
  output logic [PTR_W:0]         entry_count,
  output logic                   full
);

  typedef struct packed {
    opcode_t                  opc;
    logic signed [OP_W-1:0]   op_a;
    logic signed [OP_W-1:0]   op_b;
    logic signed [2*OP_W-1:0] result;
    logic                     err;
  } entry_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  entry_t                   mem_q [DEPTH];
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [PTR_W:0]           count_q, count_d;
  entry_t                   rd_word_q, rd_word_d;
  logic                     rd_err_q, rd_err_d;

  entry_t                   wr_entry;
  logic signed [2*OP_W-1:0] alu_result;
  logic                     alu_err;
  logic                     wr_hit, wr_en, rd_hit;

  instr_alu #(.OP_W(OP_W)) u_alu (
    .opcode_i (opcode),
    .op_a_i   (operand_a),
    .op_b_i   (operand_b),
    .result_o (alu_result),
    .err_o    (alu_err)
  );

  assign wr_entry = '{opc: opcode, op_a: operand_a, op_b: operand_b,
                      result: alu_result, err: alu_err};

  assign wr_hit = load_en && ({1'b0, write_pointer} < DEPTH_C);
  assign wr_en  = wr_hit && !clear;
  assign rd_hit = {1'b0, read_pointer} < DEPTH_C;

  // Read samples current state, so a same-edge write or clear is not yet visible.
  always_comb begin
    valid_d   = valid_q;
    count_d   = count_q;
    rd_word_d = '0;
    rd_err_d  = 1'b1;
    if (rd_hit && valid_q[read_pointer]) begin
      rd_word_d = mem_q[read_pointer];
      rd_err_d  = 1'b0;
    end
    if (clear) begin
      valid_d = '0;
      count_d = '0;
    end else if (wr_en) begin
      if (!valid_q[write_pointer]) count_d = count_q + 1'b1;
      valid_d[write_pointer] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      count_q   <= '0;
      rd_word_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      rd_word_q <= rd_word_d;
      rd_err_q  <= rd_err_d;
    end
  end

  // Storage is not reset: the valid bits alone decide what a read can see.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[write_pointer] <= wr_entry;
  end

  assign instruction_word = rd_word_q;
  assign read_err         = rd_err_q;
  assign entry_count      = count_q;
  assign full             = (count_q == DEPTH_C);

endmodule

// File: tb/tb_instr_register_alu.sv
// Scoreboard bench for instr_register_alu at DEPTH=6, OP_W=8 (pointers 6 and 7 are out of range).
// Honours INSTR_REGISTER_DIV_EN the same way the design does.
module tb_instr_register_alu;
  import instr_register_pkg::*;

  localparam int DEPTH = 6;
  localparam int OP_W  = 8;
  localparam int PTR_W = 3;

  typedef struct packed {
    opcode_t             opc;
    logic signed [7:0]   op_a;
    logic signed [7:0]   op_b;
    logic signed [15:0]  result;
    logic                err;
  } tb_word_t;

  typedef struct packed {
    tb_word_t w;
    logic     e;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   load_en = 1'b0;
  logic                   clear = 1'b0;
  logic [PTR_W-1:0]       write_pointer = '0;
  opcode_t                opcode = ZERO;
  logic signed [OP_W-1:0] operand_a = '0;
  logic signed [OP_W-1:0] operand_b = '0;
  logic [PTR_W-1:0]       read_pointer = '0;
  logic [4*OP_W+3:0]      dut_word;
  logic                   read_err;
  logic [PTR_W:0]         entry_count;
  logic                   full;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t       exp_q[$];
  logic       m_valid [DEPTH];
  tb_word_t   m_mem   [DEPTH];
  int         m_count = 0;
  tb_word_t   got;

  instr_register_alu #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_en          (load_en),
    .clear            (clear),
    .write_pointer    (write_pointer),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .read_pointer     (read_pointer),
    .instruction_word (dut_word),
    .read_err         (read_err),
    .entry_count      (entry_count),
    .full             (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic void alu_model(input opcode_t opc, input logic signed [7:0] a,
                                    input logic signed [7:0] b,
                                    output logic signed [15:0] r, output logic e);
    int ai = a;
    int bi = b;
    r = '0;
    e = 1'b0;
    case (opc)
      PASSA: r = 16'(ai);
      PASSB: r = 16'(bi);
      ADD:   r = 16'(ai + bi);
      SUB:   r = 16'(ai - bi);
      MULT:  r = 16'(ai * bi);
`ifdef INSTR_REGISTER_DIV_EN
      DIV:   if (bi == 0) e = 1'b1; else r = 16'(ai / bi);
      MOD:   if (bi == 0) e = 1'b1; else r = 16'(ai % bi);
`else
      DIV:   e = 1'b1;
      MOD:   e = 1'b1;
`endif
      default: r = '0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_count = 0;
  endtask

  task automatic step(input logic ld, input logic clr, input logic [2:0] wp, input opcode_t opc,
                      input logic signed [7:0] a, input logic signed [7:0] b,
                      input logic [2:0] rp);
    exp_t     ex;
    tb_word_t nw;
    load_en = ld; clear = clr; write_pointer = wp; opcode = opc;
    operand_a = a; operand_b = b; read_pointer = rp;
    ex.w = '0;
    ex.e = 1'b1;
    if (int'(rp) < DEPTH) begin
      if (m_valid[rp]) begin
        ex.w = m_mem[rp];
        ex.e = 1'b0;
      end
    end
    exp_q.push_back(ex);
    if (clr) begin
      model_reset();
    end else if (ld && int'(wp) < DEPTH) begin
      nw.opc = opc; nw.op_a = a; nw.op_b = b;
      alu_model(opc, a, b, nw.result, nw.err);
      if (!m_valid[wp]) m_count++;
      m_valid[wp] = 1'b1;
      m_mem[wp] = nw;
    end
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    got = tb_word_t'(dut_word);
    chk("rd_word", dut_word, ex.w);
    chk("rd_err", read_err, ex.e);
    chk("count", entry_count, m_count);
    chk("full", full, m_count == DEPTH);
    load_en = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_word", dut_word, 0);
    chk("rst_err", read_err, 0);
    chk("rst_count", entry_count, 0);
    chk("rst_full", full, 0);
    @(negedge clk);
    reset_n = 1'b1;

    step(1, 0, 0, ADD, 5, -3, 0);
    step(1, 0, 1, MULT, -15, 15, 0);
    chk("add_res", got.result, 2);
    chk("add_err", got.err, 0);
    chk("add_cnt", entry_count, 2);
    step(1, 0, 2, DIV, 7, 0, 1);
    chk("mult_res", got.result, -225);
    step(1, 0, 3, DIV, 7, 2, 2);
    chk("div0_res", got.result, 0);
    chk("div0_err", got.err, 1);
    step(1, 0, 4, SUB, 9, 4, 3);
`ifdef INSTR_REGISTER_DIV_EN
    chk("div_res", got.result, 3);
    chk("div_err", got.err, 0);
`else
    chk("div_res", got.result, 0);
    chk("div_err", got.err, 1);
`endif
    step(1, 0, 4, PASSA, 1, 0, 4);
    chk("rbw_old", got.result, 5);
    step(1, 0, 5, MOD, -7, 3, 4);
    chk("rbw_new", got.result, 1);
    chk("full_set", full, 1);
    step(1, 0, 3, PASSB, 0, -8, 5);
    chk("ovw_cnt", entry_count, DEPTH);
    step(1, 0, 7, ADD, 1, 1, 6);
    chk("oor_err", read_err, 1);
    step(1, 1, 0, ADD, 2, 2, 3);
    chk("clr_pre", got.result, -8);
    chk("clr_cnt", entry_count, 0);
    step(0, 0, 0, ZERO, 0, 0, 0);
    chk("clr_rd_err", read_err, 1);
    chk("clr_rd_word", dut_word, 0);

    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)),
           opcode_t'($urandom_range(0, 7)), 8'($urandom), 8'($urandom_range(0, 4)),
           3'($urandom_range(0, 7)));

    step(1, 0, 0, PASSA, 11, 0, 0);
    step(1, 0, 1, PASSB, 0, 12, 0);
    chk("pre_rst_word", got.result, 11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_word", dut_word, 0);
    chk("async_err", read_err, 0);
    chk("async_cnt", entry_count, 0);
    chk("async_full", full, 0);
    model_reset();
    load_en = 1'b1; write_pointer = 2; opcode = ADD; operand_a = 3; operand_b = 3;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 2, ADD, 1, 1, 0);
    chk("post_rst_err0", read_err, 1);
    chk("post_rst_cnt", entry_count, 1);
    step(0, 0, 0, ZERO, 0, 0, 1);
    chk("post_rst_err1", read_err, 1);
    step(0, 0, 0, ZERO, 0, 0, 2);
    chk("post_rst_wr", got.result, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_register_alu.md
INSTR_REGISTER_ALU -- requirements
Module: instr_register_alu

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of register locations (2..256).
REQ-002 SHALL have parameter OP_W, default 32, signed operand width.
REQ-003 SHALL have parameter PTR_W, default $clog2(DEPTH), pointer width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port load_en  input  1  write strobe.
REQ-007 SHALL have port clear  input  1  synchronous invalidate of all locations.
REQ-008 SHALL have port write_pointer  input  PTR_W  write address.
REQ-009 SHALL have port opcode  input  opcode_t  operation.
REQ-010 SHALL have port operand_a, operand_b  input  OP_W each  signed operands.
REQ-011 SHALL have port read_pointer  input  PTR_W  read address, sampled every cycle.
REQ-012 SHALL have port instruction_word  output  instruction_t  registered read data: opc, op_a, op_b, result (2*OP_W signed), err.
REQ-013 SHALL have port read_err  output  1  registered; last read hit an unwritten or out-of-range location.
REQ-014 SHALL have port entry_count  output  PTR_W+1  number of valid locations.
REQ-015 SHALL have port full  output  1  entry_count == DEPTH.

Function
REQ-016 On load_en=1 with write_pointer < DEPTH, SHALL store opc/op_a/op_b plus computed result and err, and mark the location valid, at the same edge.
REQ-017 Result: ZERO=0, PASSA=op_a, PASSB=op_b, ADD=a+b, SUB=a-b, MULT=a*b, DIV=a/b, MOD=a%b; sign-extended to 2*OP_W, no truncation.
REQ-018 DIV or MOD with op_b=0 SHALL store result=0, err=1; all other cases err=0.
REQ-019 write_pointer >= DEPTH SHALL ignore the write; no state changes.
REQ-020 Read latency SHALL be one cycle: instruction_word/read_err reflect read_pointer from the previous edge.
REQ-021 Reading an invalid or out-of-range location SHALL give instruction_word=0, read_err=1.
REQ-022 Simultaneous write and read of the same location SHALL return pre-write contents (read-before-write).
REQ-023 entry_count SHALL increment only when writing a previously invalid location; overwrite leaves it unchanged; it never exceeds DEPTH.
REQ-024 clear=1 SHALL invalidate all locations and zero entry_count at the edge; clear wins over a simultaneous load_en, and the read in that cycle returns pre-clear contents.

Reset
REQ-025 reset_n=0 SHALL asynchronously zero instruction_word, read_err, entry_count, full and all valid bits; storage contents need not reset.
REQ-026 Reset asserted mid-write SHALL discard that write; first write is accepted on the first edge with reset_n=1.

Configuration
REQ-027 With INSTR_REGISTER_DIV_EN defined, DIV/MOD SHALL behave per REQ-017/018.
REQ-028 Without INSTR_REGISTER_DIV_EN, DIV/MOD SHALL store result=0, err=1, and no divider logic SHALL be synthesised.

Structure
REQ-029 opcode_t (ZERO,PASSA,PASSB,ADD,SUB,MULT,DIV,MOD = 0..7), instruction_t and the default OP_W SHALL live in instr_register_pkg.
REQ-030 Result computation SHALL be a combinational sub-module instr_alu (opcode, operands -> result, err).

Verification
REQ-031 Reset, then write ADD a=5 b=-3 at loc 0, read loc 0 -> next cycle result=2, err=0, read_err=0, entry_count=1.
REQ-032 MULT a=-15 b=15 at loc 1 (OP_W=8) -> result=-225 (16-bit), no overflow.
REQ-033 DIV a=7 b=0, with and without INSTR_REGISTER_DIV_EN -> result=0, err=1; DIV a=7 b=2 -> 3 with macro, 0/err=1 without.
REQ-034 Write all DEPTH locations, then overwrite loc 3 -> full=1, entry_count=DEPTH; read unwritten loc after clear -> 0, read_err=1.
REQ-035 Same-cycle write and read of loc 4 (old SUB 9-4) with new PASSA 1 -> read returns result 5; next read returns 1.
REQ-036 Assert reset_n mid-sequence between edges -> outputs zero immediately; prior locations read back read_err=1.
